// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle CPU. It takes the opcode held in the
// instruction register, steps each instruction through 3 to 5 states, and
// drives every datapath enable and mux select from the registered state.
// It stalls on MemReady in FETCH, MEMREAD and MEMWRITE. It also counts
// retired instructions and keeps a sticky flag for illegal opcodes.
// Optional feature macro: MULTICYCLE_ADDI_EN. When it is defined, opcode
// 001000 runs as addi through the ADDIEX/ADDIWB states. When it is not
// defined, 001000 is treated as an illegal opcode.
module multicycle_control_fsm #(
    parameter int STATE_WIDTH = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [5:0]             Opcode,
    input  logic                   MemReady,
    output logic                   PCWrite,
    output logic                   PCWriteCond,
    output logic                   IorD,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   MemtoReg,
    output logic                   IRWrite,
    output logic [1:0]             PCSource,
    output logic [1:0]             ALUOp,
    output logic                   ALUSrcA,
    output logic [1:0]             ALUSrcB,
    output logic                   RegWrite,
    output logic                   RegDst,
    output logic [STATE_WIDTH-1:0] State,
    output logic [COUNT_WIDTH-1:0] InstrCount,
    output logic                   IllegalOp
);

    localparam logic [STATE_WIDTH-1:0] S_FETCH    = 'd0;
    localparam logic [STATE_WIDTH-1:0] S_DECODE   = 'd1;
    localparam logic [STATE_WIDTH-1:0] S_MEMADDR  = 'd2;
    localparam logic [STATE_WIDTH-1:0] S_MEMREAD  = 'd3;
    localparam logic [STATE_WIDTH-1:0] S_MEMWB    = 'd4;
    localparam logic [STATE_WIDTH-1:0] S_MEMWRITE = 'd5;
    localparam logic [STATE_WIDTH-1:0] S_EXECUTE  = 'd6;
    localparam logic [STATE_WIDTH-1:0] S_RWB      = 'd7;
    localparam logic [STATE_WIDTH-1:0] S_BRANCH   = 'd8;
    localparam logic [STATE_WIDTH-1:0] S_JUMP     = 'd9;
`ifdef MULTICYCLE_ADDI_EN
    localparam logic [STATE_WIDTH-1:0] S_ADDIEX   = 'd10;
    localparam logic [STATE_WIDTH-1:0] S_ADDIWB   = 'd11;
    localparam logic [5:0]             OP_ADDI    = 6'b001000;
`endif

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    logic [STATE_WIDTH-1:0] state_q, state_d;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   ill_q, ill_d;
    logic                   retire;

    // Ungated control values decoded from the registered state
    logic       pcw, pcwc, iord, mrd, mwr, m2r, irw, alusa, rw, rdst;
    logic [1:0] pcsrc, aluop, alusb;

    // Next-state logic, including retirement and illegal-opcode detection
    always_comb begin
        state_d = S_FETCH;
        retire  = 1'b0;
        ill_d   = ill_q;
        case (state_q)
            S_FETCH:    state_d = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (Opcode == OP_LW || Opcode == OP_SW) state_d = S_MEMADDR;
                else if (Opcode == OP_R)                state_d = S_EXECUTE;
                else if (Opcode == OP_BEQ)              state_d = S_BRANCH;
                else if (Opcode == OP_J)                state_d = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
                else if (Opcode == OP_ADDI)             state_d = S_ADDIEX;
`endif
                else begin
                    state_d = S_FETCH;
                    ill_d   = 1'b1;
                end
            end
            S_MEMADDR: begin
                if (Opcode == OP_LW)      state_d = S_MEMREAD;
                else if (Opcode == OP_SW) state_d = S_MEMWRITE;
                else                      state_d = S_FETCH;
            end
            S_MEMREAD:  state_d = MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    retire  = 1'b1;
            S_MEMWRITE: begin
                state_d = MemReady ? S_FETCH : S_MEMWRITE;
                retire  = MemReady;
            end
            S_EXECUTE:  state_d = S_RWB;
            S_RWB:      retire  = 1'b1;
            S_BRANCH:   retire  = 1'b1;
            S_JUMP:     retire  = 1'b1;
`ifdef MULTICYCLE_ADDI_EN
            S_ADDIEX:   state_d = S_ADDIWB;
            S_ADDIWB:   retire  = 1'b1;
`endif
            default:    state_d = S_FETCH;
        endcase
        cnt_d = retire ? cnt_q + COUNT_WIDTH'(1) : cnt_q;
    end

    // State register, retire counter and sticky illegal flag
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
        end
    end

    // Decode control outputs from the state. FETCH also depends on MemReady.
    always_comb begin
        pcw = 1'b0; pcwc = 1'b0; iord = 1'b0; mrd = 1'b0; mwr = 1'b0;
        m2r = 1'b0; irw = 1'b0; alusa = 1'b0; rw = 1'b0; rdst = 1'b0;
        pcsrc = 2'b00; aluop = 2'b00; alusb = 2'b00;
        case (state_q)
            S_FETCH: begin
                mrd = 1'b1; alusb = 2'b01; irw = MemReady; pcw = MemReady;
            end
            S_DECODE:   alusb = 2'b11;
            S_MEMADDR:  begin alusa = 1'b1; alusb = 2'b10; end
            S_MEMREAD:  begin mrd = 1'b1; iord = 1'b1; end
            S_MEMWB:    begin rw = 1'b1; m2r = 1'b1; end
            S_MEMWRITE: begin mwr = 1'b1; iord = 1'b1; end
            S_EXECUTE:  begin alusa = 1'b1; aluop = 2'b10; end
            S_RWB:      begin rw = 1'b1; rdst = 1'b1; end
            S_BRANCH: begin
                alusa = 1'b1; aluop = 2'b01; pcwc = 1'b1; pcsrc = 2'b01;
            end
            S_JUMP:     begin pcw = 1'b1; pcsrc = 2'b10; end
`ifdef MULTICYCLE_ADDI_EN
            S_ADDIEX:   begin alusa = 1'b1; alusb = 2'b10; end
            S_ADDIWB:   rw = 1'b1;
`endif
            default: ;
        endcase
    end

    // Reset_n gates every control output asynchronously. This drops a write
    // strobe immediately when reset is asserted in the middle of a store.
    assign PCWrite     = pcw   & Reset_n;
    assign PCWriteCond = pcwc  & Reset_n;
    assign IorD        = iord  & Reset_n;
    assign MemRead     = mrd   & Reset_n;
    assign MemWrite    = mwr   & Reset_n;
    assign MemtoReg    = m2r   & Reset_n;
    assign IRWrite     = irw   & Reset_n;
    assign ALUSrcA     = alusa & Reset_n;
    assign RegWrite    = rw    & Reset_n;
    assign RegDst      = rdst  & Reset_n;
    assign PCSource    = pcsrc & {2{Reset_n}};
    assign ALUOp       = aluop & {2{Reset_n}};
    assign ALUSrcB     = alusb & {2{Reset_n}};
    assign State       = state_q;
    assign InstrCount  = cnt_q;
    assign IllegalOp   = ill_q;

endmodule
